serial_mag_cmp: RTL and testbench

- Sequential unsigned magnitude comparator for WIDTH-bit operands.
- Scans the operands MSB-first, 2 bits per clock, using a combinational 2-bit slice comparator.
- Terminates early at the first differing bit pair and reports eq/gt/lt with a start/done handshake.
- Sits downstream of the operand registers and feeds the lab's result/LED display logic.

---
 rtl/serial_mag_cmp_pkg.sv | 18 +
 rtl/serial_mag_cmp_cmp2_slice.sv | 13 +
 rtl/serial_mag_cmp.sv | 93 +++++++++
 tb/tb_serial_mag_cmp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the pair-counter width helper.
package serial_mag_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // CNT_W: bits needed to count NPAIR-1 down to zero, never narrower than 1.
  function automatic int cnt_w_for(input int npair);
    return ($clog2(npair) < 1) ? 1 : $clog2(npair);
  endfunction

endpackage

// File: rtl/serial_mag_cmp_cmp2_slice.sv
// Combinational 2-bit unsigned compare; the comparator scans operands one
// slice at a time through this block.
module cmp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       eq,
  output logic       gt
);

  assign eq = (x == y);
  assign gt = (x > y);

endmodule

// File: rtl/serial_mag_cmp.sv
// Sequential unsigned magnitude comparator: scans A and B MSB-first, two bits
// per clock, and stops at the first differing pair.
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT  // must be even and >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NPAIR = WIDTH / 2;
  localparam int CNT_W = cnt_w_for(NPAIR);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CNT_W-1:0] cnt;
  logic             slice_eq, slice_gt;
  logic             accept, last_pair;

  cmp2_slice u_slice (
    .x  (sa[WIDTH-1 -: 2]),
    .y  (sb[WIDTH-1 -: 2]),
    .eq (slice_eq),
    .gt (slice_gt)
  );

  assign accept    = (state == ST_IDLE) && start;
  assign last_pair = (cnt == '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first guarantees state_nxt is written on
  // every path, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (!slice_eq || last_pair) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every datapath register, shift registers included, has a reset
  // value so nothing can leak X into the result flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      eq  <= 1'b0;
      gt  <= 1'b0;
      lt  <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      cnt <= CNT_W'(NPAIR - 1);
    end else if (state == ST_RUN) begin
      if (!slice_eq) begin
        eq <= 1'b0;
        gt <= slice_gt;
        lt <= !slice_gt;
      end else if (last_pair) begin
        eq <= 1'b1;
        gt <= 1'b0;
        lt <= 1'b0;
      end else begin
        sa  <= sa << 2;
        sb  <= sb << 2;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Decoded straight from state so reset clears them without waiting for a clock.
  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp (WIDTH=8): directed vector table,
// hand-written handshake/reset sequences and randomized compares vs a model.
module tb_serial_mag_cmp;

  localparam int WIDTH = 8;
  localparam int NPAIR = WIDTH / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             busy, done, eq, gt, lt;

  int checks   = 0;
  int failures = 0;
  logic [2:0] prev_res;  // {eq,gt,lt} expected to be held until the next decision

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             e_eq;
    logic             e_gt;
    logic             e_lt;
    int               lat;
  } vec_t;

  vec_t vecs[9];

  serial_mag_cmp #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned compare; decision edge from the highest differing bit.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic e, output logic g, output logic l, output int lat);
    logic [WIDTH-1:0] diff;
    int hi;
    e    = (a == b);
    g    = (a > b);
    l    = (a < b);
    diff = a ^ b;
    hi   = -1;
    for (int i = 0; i < WIDTH; i++) if (diff[i]) hi = i;
    lat  = (hi < 0) ? NPAIR : ((WIDTH - 1 - hi) / 2) + 1;
  endtask

  // Drive a request so it is accepted on the next edge; scramble a/b afterwards.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = WIDTH'($urandom);
    b_in  = WIDTH'($urandom);
    check("busy_accept", busy, 1);
  endtask

  // Waits (bounded) for done; ends at the negedge of the done cycle.
  task automatic wait_result(input logic e_eq, input logic e_gt, input logic e_lt, input int e_lat);
    int lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      check("busy_run", busy, 1);
      check("hold_prev", {eq, gt, lt}, prev_res);
    end
    check("latency", lat, e_lat);
    check("busy_done", busy, 1);
    check("result", {eq, gt, lt}, {e_eq, e_gt, e_lt});
    prev_res = {e_eq, e_gt, e_lt};
  endtask

  task automatic finish_idle();
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
    check("result_held", {eq, gt, lt}, prev_res);
  endtask

  task automatic run_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic e_eq, input logic e_gt, input logic e_lt, input int e_lat);
    issue(a, b);
    wait_result(e_eq, e_gt, e_lt, e_lat);
    finish_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic m_eq, m_gt, m_lt;
    int   m_lat;
    logic [WIDTH-1:0] ra, rb;

    vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 4};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[5] = '{8'h0C, 8'h08, 1'b0, 1'b1, 1'b0, 3};
    vecs[6] = '{8'h30, 8'h34, 1'b0, 1'b0, 1'b1, 3};
    vecs[7] = '{8'h40, 8'h3F, 1'b0, 1'b1, 1'b0, 1};
    vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4};

    reset    = 1'b1;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    prev_res = 3'b000;
    #1;
    check("reset_outputs", {busy, done, eq, gt, lt}, 5'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, done, eq, gt, lt}, 5'b0);

    for (int i = 0; i < 9; i++)
      run_compare(vecs[i].a, vecs[i].b, vecs[i].e_eq, vecs[i].e_gt, vecs[i].e_lt, vecs[i].lat);

    // start re-pulsed during RUN with swapped operands must be ignored
    issue(8'hFF, 8'h00);
    start = 1'b1;
    a_in  = 8'h00;
    b_in  = 8'hFF;
    dones = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) start = 1'b0;
      @(negedge clk);
      if (done) dones++;
    end
    check("repulse_one_done", dones, 1);
    check("repulse_result", {eq, gt, lt}, 3'b010);
    check("repulse_idle", busy, 0);
    prev_res = 3'b010;

    // asynchronous reset in the middle of a scan
    issue(8'h55, 8'h56);
    @(posedge clk);
    @(negedge clk);
    check("mid_run_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {busy, done, eq, gt, lt}, 5'b0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    prev_res = 3'b000;
    run_compare(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 4);

    // result hold through idle, then start during DONE only vs. the next cycle
    run_compare(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("hold_idle", {busy, eq, gt, lt}, 4'b0010);
    end
    issue(8'h40, 8'h3F);
    wait_result(1'b0, 1'b1, 1'b0, 1);
    start = 1'b1;
    a_in  = 8'h12;
    b_in  = 8'h13;
    @(posedge clk);
    #1;
    check("done_start_ignored", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 8'hFF;
    b_in  = 8'h00;
    check("next_start_accepted", busy, 1);
    wait_result(1'b0, 1'b0, 1'b1, 4);
    finish_idle();

    // randomized compares, about a quarter with equal operands
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      model(ra, rb, m_eq, m_gt, m_lt, m_lat);
      run_compare(ra, rb, m_eq, m_gt, m_lt, m_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
